// File: rtl/rc4_key_search_ctrl_if.sv
// Controller <-> phase-block/RAM bundle for the RC4 key search scheduler.
// The master modport is the controller side, the slave modport is the phase-block/RAM side.
`timescale 1ns/1ps
interface rc4_key_search_ctrl_if;
  // Handshake: a phase runs while its *_start is high; the phase raises its latched
  // *_done, the controller drops *_start and pulses sub_reset, which clears that done.
  logic        start;
  logic        sub_reset;
  logic        init_start;
  logic        shuf_start;
  logic        dec_start;
  logic        init_done;
  logic        shuf_done;
  logic        dec_done;
  logic        dec_valid;
  logic [7:0]  init_addr;
  logic [7:0]  shuf_addr;
  logic [7:0]  dec_addr;
  logic [7:0]  init_data;
  logic [7:0]  shuf_data;
  logic [7:0]  dec_data;
  logic        init_write;
  logic        shuf_write;
  logic        dec_write;
  logic [7:0]  mem_addr;
  logic [7:0]  mem_data;
  logic        mem_write;
  logic [23:0] secret_key;
  logic        busy;
  logic        key_found;
  logic        key_exhausted;
  logic [3:0]  state_dbg;

  modport master (
    input  start, init_done, shuf_done, dec_done, dec_valid,
           init_addr, shuf_addr, dec_addr, init_data, shuf_data, dec_data,
           init_write, shuf_write, dec_write,
    output sub_reset, init_start, shuf_start, dec_start,
           mem_addr, mem_data, mem_write, secret_key,
           busy, key_found, key_exhausted, state_dbg
  );

  modport slave (
    output start, init_done, shuf_done, dec_done, dec_valid,
           init_addr, shuf_addr, dec_addr, init_data, shuf_data, dec_data,
           init_write, shuf_write, dec_write,
    input  sub_reset, init_start, shuf_start, dec_start,
           mem_addr, mem_data, mem_write, secret_key,
           busy, key_found, key_exhausted, state_dbg
  );
endinterface

// File: rtl/rc4_key_search_ctrl.sv
// RC4 brute-force scheduler: runs init/shuffle/decrypt per candidate key and owns the S-RAM mux.
// Optional per-phase watchdog enabled by defining RC4_PHASE_TIMEOUT_EN.
`timescale 1ns/1ps
module rc4_key_search_ctrl #(
  parameter logic [23:0] KEY_START      = 24'h000000,
  parameter logic [23:0] KEY_END        = 24'h3FFFFF,
  parameter int          TIMEOUT_CYCLES = 2048
) (
  input  logic                 clk,
  input  logic                 reset_n,
  rc4_key_search_ctrl_if.master bus
);

  typedef enum logic [3:0] {
    S_IDLE, S_CLR, S_INIT, S_CLR2, S_SHUF, S_CLR3, S_DEC, S_CHECK, S_NEXT,
    S_FOUND, S_EXHAUSTED
`ifdef RC4_PHASE_TIMEOUT_EN
    , S_TIMEOUT
`endif
  } state_t;

  // The watchdog is 12 bits wide, so the limit must fit in 1..4096.
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 4096) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES out of range");
  end

  state_t      state_q, state_d;
  logic [23:0] key_q, key_d;

`ifdef RC4_PHASE_TIMEOUT_EN
  localparam logic [11:0] TO_LAST = 12'(TIMEOUT_CYCLES - 1);
  logic [11:0] wdog_q, wdog_d;
  logic        in_phase;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      key_q   <= KEY_START;
`ifdef RC4_PHASE_TIMEOUT_EN
      wdog_q  <= 12'd0;
`endif
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
`ifdef RC4_PHASE_TIMEOUT_EN
      wdog_q  <= wdog_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    case (state_q)
      S_IDLE, S_FOUND, S_EXHAUSTED: begin
        if (bus.start) begin
          state_d = S_CLR;
          key_d   = KEY_START;
        end
      end
`ifdef RC4_PHASE_TIMEOUT_EN
      S_TIMEOUT: begin
        if (bus.start) begin
          state_d = S_CLR;
          key_d   = KEY_START;
        end
      end
`endif
      S_CLR:   state_d = S_INIT;
      S_INIT:  if (bus.init_done) state_d = S_CLR2;
      S_CLR2:  state_d = S_SHUF;
      S_SHUF:  if (bus.shuf_done) state_d = S_CLR3;
      S_CLR3:  state_d = S_DEC;
      S_DEC:   if (bus.dec_done) state_d = S_CHECK;
      S_CHECK: begin
        if (bus.dec_valid)        state_d = S_FOUND;
        else if (key_q == KEY_END) state_d = S_EXHAUSTED;
        else                      state_d = S_NEXT;
      end
      S_NEXT: begin
        key_d   = key_q + 24'd1;
        state_d = S_CLR;
      end
      default: state_d = S_IDLE;
    endcase
`ifdef RC4_PHASE_TIMEOUT_EN
    // A phase that has not finished by its last allowed cycle is abandoned.
    if (in_phase && state_d == state_q && wdog_q == TO_LAST) state_d = S_TIMEOUT;
`endif
  end

`ifdef RC4_PHASE_TIMEOUT_EN
  assign in_phase = (state_q == S_INIT) || (state_q == S_SHUF) || (state_q == S_DEC);
  assign wdog_d   = (in_phase && state_d == state_q) ? wdog_q + 12'd1 : 12'd0;
`endif

  always_comb begin
    bus.sub_reset     = 1'b0;
    bus.busy          = 1'b1;
    bus.key_found     = 1'b0;
    bus.key_exhausted = 1'b0;
    case (state_q)
      S_IDLE:                  begin bus.sub_reset = 1'b1; bus.busy = 1'b0; end
      S_CLR, S_CLR2, S_CLR3,
      S_NEXT:                  bus.sub_reset = 1'b1;
      S_FOUND:                 begin bus.busy = 1'b0; bus.key_found = 1'b1; end
      S_EXHAUSTED:             begin bus.busy = 1'b0; bus.key_exhausted = 1'b1; end
`ifdef RC4_PHASE_TIMEOUT_EN
      S_TIMEOUT: begin
        bus.busy          = 1'b0;
        bus.key_exhausted = 1'b1;
        bus.sub_reset     = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  assign bus.init_start = (state_q == S_INIT);
  assign bus.shuf_start = (state_q == S_SHUF);
  assign bus.dec_start  = (state_q == S_DEC);
  assign bus.secret_key = key_q;
  assign bus.state_dbg  = state_q;

  // Only the phase that owns the current state reaches the RAM.
  always_comb begin
    bus.mem_addr  = 8'h00;
    bus.mem_data  = 8'h00;
    bus.mem_write = 1'b0;
    case (state_q)
      S_INIT: begin
        bus.mem_addr  = bus.init_addr;
        bus.mem_data  = bus.init_data;
        bus.mem_write = bus.init_write;
      end
      S_SHUF: begin
        bus.mem_addr  = bus.shuf_addr;
        bus.mem_data  = bus.shuf_data;
        bus.mem_write = bus.shuf_write;
      end
      S_DEC: begin
        bus.mem_addr  = bus.dec_addr;
        bus.mem_data  = bus.dec_data;
        bus.mem_write = bus.dec_write;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_rc4_key_search_ctrl.sv
// Directed bench for rc4_key_search_ctrl: phase-order scoreboard, mux ownership, key stepping,
// exhaustion without wrap, async reset mid-shuffle and (with RC4_PHASE_TIMEOUT_EN) the watchdog.
`timescale 1ns/1ps
module tb_rc4_key_search_ctrl;
  localparam int W = 26;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  rc4_key_search_ctrl_if bus_a ();
  rc4_key_search_ctrl_if bus_b ();

  rc4_key_search_ctrl #(.KEY_START(24'h000000), .KEY_END(24'h000005), .TIMEOUT_CYCLES(16))
    dut_a (.clk(clk), .reset_n(rst_n), .bus(bus_a.master));
  rc4_key_search_ctrl #(.KEY_START(24'hFFFFFE), .KEY_END(24'hFFFFFF))
    dut_b (.clk(clk), .reset_n(rst_n), .bus(bus_b.master));

  logic [23:0] valid_key_a = 24'h000000;
  logic        hold_shuf_a = 1'b0;
  assign bus_a.dec_valid = (bus_a.secret_key == valid_key_a);
  assign bus_b.dec_valid = 1'b0;

  logic [W-1:0] exp_qa[$];
  logic [W-1:0] exp_qb[$];
  int dec_cnt_a = 0;
  int dec_cnt_b = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] ph_of(input logic [2:0] st);
    return (st == 3'b100) ? 2'd1 : (st == 3'b010) ? 2'd2 : (st == 3'b001) ? 2'd3 : 2'd0;
  endfunction

  function automatic logic [W-1:0] ev(input logic [1:0] p, input logic [23:0] k);
    return {p, k};
  endfunction

  task automatic push_key_a(input logic [23:0] k);
    exp_qa.push_back(ev(2'd1, k));
    exp_qa.push_back(ev(2'd2, k));
    exp_qa.push_back(ev(2'd3, k));
  endtask

  // Phase models: latched done after 3 active cycles, cleared by sub_reset.
  logic [1:0] cnt_a, cnt_b;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n || bus_a.sub_reset) begin
      cnt_a <= 2'd0;
      bus_a.init_done <= 1'b0; bus_a.shuf_done <= 1'b0; bus_a.dec_done <= 1'b0;
    end else begin
      if (cnt_a != 2'd3) cnt_a <= cnt_a + 2'd1;
      if (cnt_a >= 2'd2 && bus_a.init_start) bus_a.init_done <= 1'b1;
      if (cnt_a >= 2'd2 && bus_a.shuf_start && !hold_shuf_a) bus_a.shuf_done <= 1'b1;
      if (cnt_a >= 2'd2 && bus_a.dec_start) bus_a.dec_done <= 1'b1;
    end
  end
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n || bus_b.sub_reset) begin
      cnt_b <= 2'd0;
      bus_b.init_done <= 1'b0; bus_b.shuf_done <= 1'b0; bus_b.dec_done <= 1'b0;
    end else begin
      if (cnt_b != 2'd3) cnt_b <= cnt_b + 2'd1;
      if (cnt_b >= 2'd2 && bus_b.init_start) bus_b.init_done <= 1'b1;
      if (cnt_b >= 2'd2 && bus_b.shuf_start) bus_b.shuf_done <= 1'b1;
      if (cnt_b >= 2'd2 && bus_b.dec_start) bus_b.dec_done <= 1'b1;
    end
  end

  // Scoreboard monitors: each phase entry pops the expected {phase, key}.
  logic [2:0] prev_st_a = 3'b000, prev_st_b = 3'b000;
  logic       prev_sr_a = 1'b1, prev_sr_b = 1'b1;
  always @(negedge clk) begin
    logic [2:0] st;
    st = {bus_a.init_start, bus_a.shuf_start, bus_a.dec_start};
    if (st != 3'b000 && prev_st_a == 3'b000) begin
      check("a_onehot_start", 32'($onehot(st)), 32'd1);
      check("a_sub_reset_before_phase", 32'(prev_sr_a), 32'd1);
      check("a_queue_nonempty", 32'(exp_qa.size() != 0), 32'd1);
      if (exp_qa.size() != 0)
        check("a_phase_key", 32'(ev(ph_of(st), bus_a.secret_key)), 32'(exp_qa.pop_front()));
      if (st == 3'b001) dec_cnt_a <= dec_cnt_a + 1;
    end
    prev_st_a <= st;
    prev_sr_a <= bus_a.sub_reset;
  end
  always @(negedge clk) begin
    logic [2:0] st;
    st = {bus_b.init_start, bus_b.shuf_start, bus_b.dec_start};
    if (st != 3'b000 && prev_st_b == 3'b000) begin
      check("b_sub_reset_before_phase", 32'(prev_sr_b), 32'd1);
      check("b_queue_nonempty", 32'(exp_qb.size() != 0), 32'd1);
      if (exp_qb.size() != 0)
        check("b_phase_key", 32'(ev(ph_of(st), bus_b.secret_key)), 32'(exp_qb.pop_front()));
      if (st == 3'b001) dec_cnt_b <= dec_cnt_b + 1;
    end
    prev_st_b <= st;
    prev_sr_b <= bus_b.sub_reset;
  end

  initial begin
    int dec_before;
    int n;
    bus_a.start = 1'b0; bus_b.start = 1'b0;
    bus_a.init_addr = 8'h11; bus_a.init_data = 8'h22; bus_a.init_write = 1'b1;
    bus_a.shuf_addr = 8'h5A; bus_a.shuf_data = 8'hC3; bus_a.shuf_write = 1'b1;
    bus_a.dec_addr  = 8'h33; bus_a.dec_data  = 8'h44; bus_a.dec_write  = 1'b1;
    bus_b.init_addr = 8'h01; bus_b.init_data = 8'h02; bus_b.init_write = 1'b1;
    bus_b.shuf_addr = 8'h03; bus_b.shuf_data = 8'h04; bus_b.shuf_write = 1'b1;
    bus_b.dec_addr  = 8'h05; bus_b.dec_data  = 8'h06; bus_b.dec_write  = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_sub_reset", 32'(bus_a.sub_reset), 32'd1);
    check("rst_starts", 32'({bus_a.init_start, bus_a.shuf_start, bus_a.dec_start}), 32'd0);
    check("rst_mem", 32'({bus_a.mem_write, bus_a.mem_addr, bus_a.mem_data}), 32'd0);
    check("rst_flags", 32'({bus_a.busy, bus_a.key_found, bus_a.key_exhausted}), 32'd0);
    check("rst_key_a", 32'(bus_a.secret_key), 32'h000000);
    check("rst_key_b", 32'(bus_b.secret_key), 32'hFFFFFE);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_busy", 32'(bus_a.busy), 32'd0);

    // Sequencing + mux ownership, valid on first key
    valid_key_a = 24'h000000;
    push_key_a(24'h000000);
    bus_a.start = 1'b1; @(negedge clk); bus_a.start = 1'b0;
    check("seq_busy", 32'(bus_a.busy), 32'd1);
    for (int i = 0; i < 50 && !bus_a.init_start; i++) @(negedge clk);
    check("mux_init", 32'({bus_a.mem_write, bus_a.mem_addr, bus_a.mem_data}), 32'h11122);
    for (int i = 0; i < 50 && !bus_a.shuf_start; i++) @(negedge clk);
    check("mux_shuf", 32'({bus_a.mem_write, bus_a.mem_addr, bus_a.mem_data}), 32'h15AC3);
    for (int i = 0; i < 50 && !bus_a.sub_reset; i++) @(negedge clk);
    check("mux_clr3", 32'({bus_a.mem_write, bus_a.mem_addr, bus_a.mem_data}), 32'd0);
    for (int i = 0; i < 50 && !bus_a.dec_start; i++) @(negedge clk);
    check("mux_dec", 32'({bus_a.mem_write, bus_a.mem_addr, bus_a.mem_data}), 32'h13344);
    for (int i = 0; i < 200 && !bus_a.key_found; i++) @(negedge clk);
    check("seq_found", 32'(bus_a.key_found), 32'd1);
    check("seq_key", 32'(bus_a.secret_key), 32'h000000);
    check("seq_busy_done", 32'({bus_a.busy, bus_a.key_exhausted, bus_a.mem_write}), 32'd0);
    check("seq_queue_empty", 32'(exp_qa.size()), 32'd0);

    // Key stepping: valid only at key 3
    valid_key_a = 24'h000003;
    dec_before = dec_cnt_a;
    for (int k = 0; k <= 3; k++) push_key_a(24'(k));
    bus_a.start = 1'b1; @(negedge clk); bus_a.start = 1'b0;
    check("step_found_cleared", 32'(bus_a.key_found), 32'd0);
    for (int i = 0; i < 500 && !bus_a.key_found; i++) @(negedge clk);
    check("step_found", 32'(bus_a.key_found), 32'd1);
    check("step_key", 32'(bus_a.secret_key), 32'h000003);
    check("step_dec_phases", 32'(dec_cnt_a - dec_before), 32'd4);
    check("step_queue_empty", 32'(exp_qa.size()), 32'd0);

    // Exhaustion at top of key space, no wrap
    for (int k = 0; k < 2; k++) begin
      exp_qb.push_back(ev(2'd1, 24'hFFFFFE + 24'(k)));
      exp_qb.push_back(ev(2'd2, 24'hFFFFFE + 24'(k)));
      exp_qb.push_back(ev(2'd3, 24'hFFFFFE + 24'(k)));
    end
    bus_b.start = 1'b1; @(negedge clk); bus_b.start = 1'b0;
    for (int i = 0; i < 500 && !bus_b.key_exhausted; i++) @(negedge clk);
    check("exh_flag", 32'(bus_b.key_exhausted), 32'd1);
    check("exh_found", 32'({bus_b.key_found, bus_b.busy}), 32'd0);
    check("exh_key", 32'(bus_b.secret_key), 32'hFFFFFF);
    check("exh_dec_phases", 32'(dec_cnt_b), 32'd2);
    check("exh_queue_empty", 32'(exp_qb.size()), 32'd0);
    repeat (3) @(negedge clk);
    check("exh_key_hold", 32'(bus_b.secret_key), 32'hFFFFFF);

    // Async reset in the middle of SHUF for key 2
    for (int k = 0; k <= 1; k++) push_key_a(24'(k));
    exp_qa.push_back(ev(2'd1, 24'h000002));
    exp_qa.push_back(ev(2'd2, 24'h000002));
    bus_a.start = 1'b1; @(negedge clk); bus_a.start = 1'b0;
    for (int i = 0; i < 500 && !(bus_a.shuf_start && bus_a.secret_key == 24'h000002); i++)
      @(negedge clk);
    check("ar_reached_shuf", 32'(bus_a.shuf_start), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("ar_sub_reset", 32'(bus_a.sub_reset), 32'd1);
    check("ar_starts", 32'({bus_a.init_start, bus_a.shuf_start, bus_a.dec_start}), 32'd0);
    check("ar_mem", 32'({bus_a.mem_write, bus_a.mem_addr, bus_a.mem_data}), 32'd0);
    check("ar_flags", 32'({bus_a.busy, bus_a.key_found, bus_a.key_exhausted}), 32'd0);
    check("ar_key", 32'(bus_a.secret_key), 32'h000000);
    check("ar_b_flags", 32'({bus_b.key_exhausted, bus_b.secret_key}), 32'h0FFFFFE);
    check("ar_queue_empty", 32'(exp_qa.size()), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    valid_key_a = 24'h000001;
    for (int k = 0; k <= 1; k++) push_key_a(24'(k));
    bus_a.start = 1'b1; @(negedge clk); bus_a.start = 1'b0;
    for (int i = 0; i < 500 && !bus_a.key_found; i++) @(negedge clk);
    check("ar_restart_found", 32'(bus_a.key_found), 32'd1);
    check("ar_restart_key", 32'(bus_a.secret_key), 32'h000001);
    check("ar_restart_queue", 32'(exp_qa.size()), 32'd0);

`ifdef RC4_PHASE_TIMEOUT_EN
    // Watchdog: shuffle never finishes
    hold_shuf_a = 1'b1;
    exp_qa.push_back(ev(2'd1, 24'h000000));
    exp_qa.push_back(ev(2'd2, 24'h000000));
    bus_a.start = 1'b1; @(negedge clk); bus_a.start = 1'b0;
    for (int i = 0; i < 100 && !bus_a.shuf_start; i++) @(negedge clk);
    check("to_shuf_entered", 32'(bus_a.shuf_start), 32'd1);
    n = 0;
    while (!bus_a.key_exhausted && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("to_cycles", 32'(n), 32'd16);
    check("to_flags", 32'({bus_a.key_exhausted, bus_a.key_found, bus_a.busy}), 32'b100);
    check("to_mem_write", 32'(bus_a.mem_write), 32'd0);
    check("to_sub_reset", 32'(bus_a.sub_reset), 32'd1);
    hold_shuf_a = 1'b0;
`endif

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
